// File: rtl/mbox_rr_arbiter.sv
// Round-robin arbiter for the shared mailbox port: one-hot registered grant,
// optional lock across transfers, watchdog release on a stalled transfer.
module mbox_rr_arbiter #(
    parameter int N_NUMB_CPU  = 4,
    parameter int TIMEOUT_CYC = 255,
    parameter int ID_W        = $clog2(N_NUMB_CPU)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [N_NUMB_CPU-1:0] req_i,
    input  logic [N_NUMB_CPU-1:0] lock_i,
    input  logic                  done_i,
    output logic [N_NUMB_CPU-1:0] gnt_o,
    output logic                  gnt_valid_o,
    output logic [ID_W-1:0]       gnt_id_o,
    output logic [N_NUMB_CPU-1:0] timeout_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ID_W-1:0]       r_ptr;
    logic [ID_W-1:0]       r_id;
    logic [N_NUMB_CPU-1:0] r_gnt;
    logic [N_NUMB_CPU-1:0] r_timeout;
    logic                  r_busy;
    logic [15:0]           r_timer;

    logic [ID_W-1:0]       w_winner;
    logic                  w_any_req;
    logic                  w_owner_req;
    logic                  w_keep;
    logic                  w_timer_hit;
    logic                  w_timeout_evt;
    logic [N_NUMB_CPU-1:0] w_gnt_nxt;
    logic [N_NUMB_CPU-1:0] w_timeout_nxt;
    logic                  w_busy_nxt;

    // First requester at or after ptr, wrapping explicitly at N_NUMB_CPU-1.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_NUMB_CPU-1:0] req,
                                                input logic [ID_W-1:0]       ptr);
        logic [ID_W-1:0] pick;
        logic            found;
        int              k;
        int              j;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_NUMB_CPU; i++) begin
            k = int'(ptr) + i;
            j = (k >= N_NUMB_CPU) ? (k - N_NUMB_CPU) : k;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = ID_W'(j);
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    assign w_any_req     = |req_i;
    assign w_winner      = rr_pick(req_i, r_ptr);
    assign w_owner_req   = req_i[r_id];
    assign w_keep        = done_i & lock_i[r_id] & w_owner_req;
    assign w_timer_hit   = (r_timer == 16'(TIMEOUT_CYC - 1));
    // done_i outranks the watchdog, so a coincident completion never pulses timeout.
    assign w_timeout_evt = (r_state == ST_GRANT) & ~done_i & w_owner_req & w_timer_hit;

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) w_next_state = ST_GRANT;
                else           w_next_state = ST_IDLE;
            end
            ST_GRANT: begin
                if (w_keep)            w_next_state = ST_GRANT;
                else if (done_i)       w_next_state = ST_RELEASE;
                else if (!w_owner_req) w_next_state = ST_RELEASE;
                else if (w_timer_hit)  w_next_state = ST_RELEASE;
                else                   w_next_state = ST_GRANT;
            end
            ST_RELEASE: w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        w_gnt_nxt     = '0;
        w_timeout_nxt = '0;
        w_busy_nxt    = (w_next_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) w_gnt_nxt[w_winner] = 1'b1;
                else           w_gnt_nxt = '0;
            end
            ST_GRANT: begin
                if (w_next_state == ST_GRANT) w_gnt_nxt = r_gnt;
                else                          w_gnt_nxt = '0;
                if (w_timeout_evt) w_timeout_nxt[r_id] = 1'b1;
                else               w_timeout_nxt = '0;
            end
            default: begin
                w_gnt_nxt     = '0;
                w_timeout_nxt = '0;
            end
        endcase
    end

    // Grant, owner, pointer and watchdog registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_gnt     <= '0;
            r_timeout <= '0;
            r_busy    <= 1'b0;
            r_id      <= '0;
            r_ptr     <= '0;
            r_timer   <= 16'd0;
        end else begin
            r_gnt     <= w_gnt_nxt;
            r_timeout <= w_timeout_nxt;
            r_busy    <= w_busy_nxt;
            if (r_state == ST_IDLE && w_any_req) begin
                r_id <= w_winner;
            end
            if (r_state == ST_RELEASE) begin
                r_ptr <= (r_id == ID_W'(N_NUMB_CPU - 1)) ? '0 : (r_id + ID_W'(1));
            end
            if (r_state == ST_GRANT && !w_keep) begin
                r_timer <= (r_timer == 16'hFFFF) ? r_timer : (r_timer + 16'd1);
            end else begin
                r_timer <= 16'd0;
            end
        end
    end

    assign gnt_o       = r_gnt;
    assign gnt_valid_o = |r_gnt;
    assign gnt_id_o    = r_id;
    assign timeout_o   = r_timeout;
    assign busy_o      = r_busy;

endmodule
